// File: rtl/filt_cici_ctrl.sv
// CIC interpolator sequencer. Runs on the fast clock and replaces the divided
// slow clock with a comb strobe (one cycle in R) and a continuous integrator
// enable. Samples arrive over valid/ready, one per slow period. A missing
// sample is replaced by zero and flagged. A stop flushes the filter with
// order*diff_delay zero-valued slow periods.
module filt_cici_ctrl #(
  parameter int gp_max_interpolation = 64,
  parameter int gp_cnt_width         = $clog2(gp_max_interpolation),
  parameter int gp_order             = 3,
  parameter int gp_diff_delay        = 1,
  parameter int gp_inp_width         = 16,
  parameter int gp_dp_latency        = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [gp_cnt_width-1:0] i_rate,
  input  logic                    i_s_valid,
  input  logic [gp_inp_width-1:0] i_s_data,
  output logic                    o_s_ready,
  output logic                    o_dp_clr,
  output logic                    o_comb_ena,
  output logic                    o_integ_ena,
  output logic [gp_inp_width-1:0] o_cic_data,
  output logic                    o_m_valid,
  output logic [gp_cnt_width-1:0] o_phase,
  output logic                    o_busy,
  output logic                    o_underrun,
  input  logic                    i_clr_underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int FLUSH_LEN = gp_order * gp_diff_delay;
  localparam int FCW       = (FLUSH_LEN < 1) ? 1 : $clog2(FLUSH_LEN + 1);

  logic [1:0]              state;
  logic [gp_cnt_width-1:0] phase;
  logic [gp_cnt_width-1:0] rate_m1;     // latched R-1, so the wrap test is a plain compare
  logic [gp_cnt_width-1:0] rate_m1_nxt;
  logic [FCW-1:0]          flush_cnt;
  logic                    stop_pend;
  logic                    wrap;
  logic                    underrun_set;
  int                      rate_c;

  // Integrator-enable delay line; the last tap is the datapath output valid.
  logic [gp_dp_latency-1:0] vld_pipe;
  logic [gp_dp_latency:0]   vld_in;

  assign wrap         = (phase == rate_m1);
  assign o_s_ready    = (state == ST_RUN) && wrap && !stop_pend;
  assign underrun_set = o_s_ready && !i_s_valid;
  assign o_phase      = phase;
  assign o_busy       = (state != ST_IDLE);
  assign vld_in       = {vld_pipe, o_integ_ena};
  assign o_m_valid    = vld_pipe[gp_dp_latency-1];

  // Clamp the requested rate into 2..gp_max_interpolation, expressed as R-1.
  always_comb begin
    rate_c = int'(i_rate);
    if (rate_c < 2)                         rate_c = 2;
    else if (rate_c > gp_max_interpolation) rate_c = gp_max_interpolation;
    rate_m1_nxt = gp_cnt_width'(rate_c - 1);
  end

  // Sequencer: phase counter, state transitions, strobes and the comb-input sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      phase       <= '0;
      rate_m1     <= gp_cnt_width'(1);
      flush_cnt   <= '0;
      stop_pend   <= 1'b0;
      o_dp_clr    <= 1'b0;
      o_comb_ena  <= 1'b0;
      o_integ_ena <= 1'b0;
      o_cic_data  <= '0;
    end else begin
      o_dp_clr   <= 1'b0;
      o_comb_ena <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A stop arriving alongside start is simply not looked at here.
          if (i_start) begin
            rate_m1     <= rate_m1_nxt;
            phase       <= '0;
            stop_pend   <= 1'b0;
            o_dp_clr    <= 1'b1;
            o_integ_ena <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_stop) stop_pend <= 1'b1;
          if (wrap) begin
            // Comb strobe lands on phase 0 regardless of whether a sample arrived.
            phase      <= '0;
            o_comb_ena <= 1'b1;
            if (stop_pend) begin
              o_cic_data <= '0;
              flush_cnt  <= FCW'(FLUSH_LEN);
              stop_pend  <= 1'b0;
              state      <= ST_FLUSH;
            end else if (i_s_valid) begin
              o_cic_data <= i_s_data;
            end else begin
              o_cic_data <= '0;
            end
          end else begin
            phase <= phase + gp_cnt_width'(1);
          end
        end
        ST_FLUSH: begin
          if (wrap) begin
            phase <= '0;
            if (flush_cnt <= FCW'(1)) begin
              flush_cnt   <= '0;
              o_integ_ena <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              flush_cnt  <= flush_cnt - FCW'(1);
              o_comb_ena <= 1'b1;
            end
          end else begin
            phase <= phase + gp_cnt_width'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          phase       <= '0;
          o_integ_ena <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               o_underrun <= 1'b0;
    else if (underrun_set)   o_underrun <= 1'b1;
    else if (i_clr_underrun) o_underrun <= 1'b0;
  end

  // Shift the integrator enable through the datapath latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld_pipe <= '0;
    else       vld_pipe <= vld_in[gp_dp_latency-1:0];
  end

endmodule

// File: tb/tb_filt_cici_ctrl.sv
// Bench for filt_cici_ctrl: directed runs with a scoreboard of expected
// comb-input samples, checked by a monitor on every comb strobe.
module tb_filt_cici_ctrl;
  localparam int CW = 8;
  localparam int DW = 16;

  logic          i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_stop = 1'b0;
  logic          i_s_valid = 1'b0, i_clr_underrun = 1'b0;
  logic [CW-1:0] i_rate = '0;
  logic [DW-1:0] i_s_data = '0;
  logic          o_s_ready, o_dp_clr, o_comb_ena, o_integ_ena, o_m_valid;
  logic          o_busy, o_underrun;
  logic [DW-1:0] o_cic_data;
  logic [CW-1:0] o_phase;

  filt_cici_ctrl #(
    .gp_max_interpolation(64), .gp_cnt_width(CW), .gp_order(3),
    .gp_diff_delay(1), .gp_inp_width(DW), .gp_dp_latency(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_rate(i_rate), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
    .o_s_ready(o_s_ready), .o_dp_clr(o_dp_clr), .o_comb_ena(o_comb_ena),
    .o_integ_ena(o_integ_ena), .o_cic_data(o_cic_data), .o_m_valid(o_m_valid),
    .o_phase(o_phase), .o_busy(o_busy), .o_underrun(o_underrun),
    .i_clr_underrun(i_clr_underrun)
  );

  always #5 i_clk = ~i_clk;

  int            checks = 0, errors = 0;
  int            cur_r = 2;
  bit            sb_en = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            cyc = 0, last_c = 0;
  bit            have_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every comb strobe must be R cycles after the previous one and
  // carry the next expected sample.
  always @(negedge i_clk) begin
    cyc++;
    if (o_dp_clr || !o_busy) have_last = 1'b0;
    if (o_comb_ena) begin
      if (have_last) chk("comb_gap", cyc - last_c, cur_r);
      last_c    = cyc;
      have_last = 1'b1;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow got=%0h expected=none t=%0t", o_cic_data, $time);
        end else begin
          chk("cic_data", o_cic_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input int rate, input bit with_stop);
    @(posedge i_clk); #1;
    i_rate = CW'(rate); i_start = 1'b1; i_stop = with_stop;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_stop = 1'b0;
    chk("start_dp_clr", o_dp_clr, 1);
    chk("start_busy", o_busy, 1);
    chk("start_phase", o_phase, 0);
    chk("start_integ", o_integ_ena, 1);
    chk("start_comb", o_comb_ena, 0);
  endtask

  // Offer a sample (or nothing) and return just after the slow tick takes it.
  task automatic slot(input bit vld, input logic [DW-1:0] d);
    bit got = 1'b0;
    i_s_valid = vld; i_s_data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (o_s_ready) begin got = 1'b1; break; end
    end
    chk("ready_seen", got, 1);
    chk("ready_phase", o_phase, cur_r - 1);
    @(posedge i_clk); #1;
  endtask

  // Stop at phase 2, expect three zero flush ticks and the tail timing.
  task automatic do_stop(input int r);
    bit got = 1'b0;
    int cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (o_phase == 2) begin got = 1'b1; break; end
    end
    chk("stop_phase_seen", got, 1);
    i_stop = 1'b1;
    @(posedge i_clk); #1;
    i_stop = 1'b0;
    repeat (3) exp_q.push_back('0);
    for (int k = 0; k < 1000; k++) begin
      @(negedge i_clk);
      if (!o_busy) break;
      cnt++;
    end
    chk("flush_len", cnt, 4 * r - 3);
    chk("idle_integ", o_integ_ena, 0);
    chk("tail_mvalid0", o_m_valid, 1);
    @(negedge i_clk); chk("tail_mvalid1", o_m_valid, 1);
    @(negedge i_clk); chk("tail_mvalid2", o_m_valid, 0);
    chk("flush_no_underrun", o_underrun, 0);
    i_s_valid = 1'b0;
  endtask

  task automatic end_run();
    int k;
    @(negedge i_clk); i_stop = 1'b1;
    @(posedge i_clk); #1; i_stop = 1'b0;
    for (k = 0; k < 1000; k++) begin
      @(negedge i_clk);
      if (!o_busy) break;
    end
    chk("end_run_idle", (k < 1000), 1);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int maxp, p, nready;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_integ", o_integ_ena, 0);
    chk("rst_phase", o_phase, 0);
    chk("rst_ready", o_s_ready, 0);
    chk("rst_mvalid", o_m_valid, 0);
    @(negedge i_clk); i_rst = 1'b0;

    // R=4: data stream, one underrun period, sticky flag, stop with valid low.
    sb_en = 1'b1; cur_r = 4;
    start_run(4, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(DW'(i));
      slot(1'b1, DW'(i));
    end
    chk("no_underrun", o_underrun, 0);
    exp_q.push_back('0);
    slot(1'b0, 16'h0);
    chk("underrun_set", o_underrun, 1);
    exp_q.push_back(16'd4);
    slot(1'b1, 16'd4);
    chk("underrun_sticky", o_underrun, 1);
    i_s_valid = 1'b0;
    i_clr_underrun = 1'b1;
    @(posedge i_clk); #1;
    i_clr_underrun = 1'b0;
    chk("underrun_clr", o_underrun, 0);
    i_s_data = 16'h00AA;
    do_stop(4);

    // R=8: stop at phase 2 while upstream keeps offering data.
    cur_r = 8;
    start_run(8, 1'b0);
    exp_q.push_back(16'd7);
    slot(1'b1, 16'd7);
    i_s_data = 16'h00AA;
    do_stop(8);
    chk("sb_drained", exp_q.size(), 0);
    sb_en = 1'b0;

    // Rate clamping at both ends.
    cur_r = 2;
    start_run(1, 1'b0);
    maxp = 0;
    repeat (10) begin @(negedge i_clk); if (int'(o_phase) > maxp) maxp = int'(o_phase); end
    chk("clamp_lo_maxphase", maxp, 1);
    end_run();
    cur_r = 64;
    start_run(200, 1'b0);
    maxp = 0;
    repeat (140) begin @(negedge i_clk); if (int'(o_phase) > maxp) maxp = int'(o_phase); end
    chk("clamp_hi_maxphase", maxp, 63);
    end_run();

    // Start and stop together: stop discarded; later start ignored in RUN.
    cur_r = 4;
    start_run(4, 1'b1);
    nready = 0;
    repeat (20) begin @(negedge i_clk); if (o_s_ready) nready++; end
    chk("startstop_ready_cnt", nready, 5);
    chk("startstop_busy", o_busy, 1);
    @(negedge i_clk); p = int'(o_phase); i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    chk("run_start_no_clr", o_dp_clr, 0);
    chk("run_start_phase", o_phase, (p + 1) % 4);
    end_run();

    // Asynchronous reset mid-run at phase 5 of R=8 with underrun flagged.
    cur_r = 8;
    start_run(8, 1'b0);
    begin
      bit got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge i_clk);
        if (o_underrun && o_phase == 5) begin got = 1'b1; break; end
      end
      chk("pre_reset_state", got, 1);
    end
    #2 i_rst = 1'b1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_integ", o_integ_ena, 0);
    chk("arst_phase", o_phase, 0);
    chk("arst_underrun", o_underrun, 0);
    chk("arst_mvalid", o_m_valid, 0);
    chk("arst_comb_clr", {o_comb_ena, o_dp_clr, o_s_ready}, 0);
    chk("arst_cic", o_cic_data, 0);
    @(negedge i_clk); i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("post_rst_idle", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/filt_cici_ctrl.md
Name: filt_cici_ctrl

Overview:
Single-clock sequencer for the CIC interpolator datapath, running entirely on the fast (output-rate) clock. It derives the slow-rate comb strobe and the fast-rate integrator enable from a runtime-programmable interpolation factor R. It accepts input samples over a valid/ready handshake, zero-stuffs on underrun, and flushes the filter with zeros on stop. It sits between the sample source and the filter datapath, replacing the separate divided slow clock.

Parameters:
gp_max_interpolation, 64, largest supported R
gp_cnt_width, $clog2(gp_max_interpolation), phase counter / rate port width
gp_order, 3, CIC order N; sets flush length
gp_diff_delay, 1, differential delay M; sets flush length
gp_inp_width, 16, input sample width
gp_dp_latency, 2, datapath pipeline latency in fast cycles from integrator enable to valid output

Ports:
i_clk  in  1  fast clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  start request, sampled in IDLE only
i_stop  in  1  stop request, sampled in RUN only
i_rate  in  gp_cnt_width  requested R, latched on start
i_s_valid  in  1  upstream sample valid
i_s_data  in  gp_inp_width  upstream sample
o_s_ready  out  1  sample accepted when i_s_valid & o_s_ready
o_dp_clr  out  1  one-cycle datapath clear pulse
o_comb_ena  out  1  comb-section enable, one cycle per R cycles
o_integ_ena  out  1  integrator-section enable
o_cic_data  out  gp_inp_width  sample presented to comb input
o_m_valid  out  1  datapath output valid
o_phase  out  gp_cnt_width  current phase 0..R-1
o_busy  out  1  state != IDLE
o_underrun  out  1  sticky: slow tick occurred with no sample
i_clr_underrun  in  1  clears o_underrun

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): state=IDLE; all outputs 0; phase=0; latched R=2; flush counter=0; stop-pending=0; latency pipe cleared.
- States: IDLE, RUN, FLUSH.
- IDLE: o_s_ready=0, enables=0. On i_start:
  - latch R = clamp(i_rate, 2, gp_max_interpolation);
  - o_dp_clr=1 for that next cycle;
  - phase=0; go to RUN.
  - i_stop is ignored in IDLE.
- RUN:
  - o_integ_ena=1 every cycle.
  - Phase counts 0..R-1 and wraps to 0.
  - o_s_ready=1 exactly in cycles with phase==R-1 and no stop pending.
  - At phase==R-1 edge: if transfer, o_cic_data<=i_s_data; otherwise o_cic_data<=0 and o_underrun<=1.
  - o_comb_ena=1 in every phase==0 cycle except the first cycle after start, so the comb rate is unaffected by underrun.
  - i_stop sets stop-pending. i_start is ignored.
  - At the next phase==R-1 boundary with stop-pending: no accept; o_cic_data<=0; flush counter loaded with gp_order*gp_diff_delay; go to FLUSH.
- FLUSH:
  - Identical timing to RUN, with o_s_ready=0 and o_cic_data=0.
  - Flush counter decrements at each phase==R-1.
  - When the counter reaches 0 at phase==R-1: go to IDLE; o_integ_ena drops the next cycle.
  - Underrun is not flagged in FLUSH.
- o_m_valid = o_integ_ena delayed by gp_dp_latency cycles, so it stays high for gp_dp_latency cycles after leaving FLUSH.
- o_busy=1 in RUN and FLUSH.
- o_underrun: set wins over i_clr_underrun in the same cycle.
- Simultaneous i_start and i_stop in IDLE: start taken, stop discarded.
- R is constant within a run; i_rate changes take effect only at the next start.
- All outputs are registered; o_s_ready is decoded from registered phase and state.

Test Plan:
- Reset high mid-RUN at phase 5 of R=8 -> all outputs 0 within the same cycle; state IDLE; o_underrun=0.
- R=4, continuous valid data 1,2,3,... -> ready at phases 3,7,11...; o_comb_ena one cycle in four; o_cic_data=1,2,3 each held 4 cycles; o_underrun=0.
- R=4, valid dropped for one slow period -> o_cic_data=0 for that period; o_comb_ena cadence unchanged; o_underrun=1 until i_clr_underrun.
- i_rate=1 and i_rate=200 with gp_max_interpolation=64 -> latched R=2 and R=64 respectively; o_phase wraps at 1 and 63.
- R=8, N=3, M=1, stop at phase 2 -> one more slow tick in RUN with no accept, then 3 slow periods (24 cycles) of FLUSH with zero data; IDLE follows; o_m_valid falls 2 cycles after o_integ_ena.
- i_start and i_stop in the same IDLE cycle -> enters RUN with o_dp_clr pulse; no stop pending; i_start during RUN has no effect.
